// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: walks each LEGv8 instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// owns the PC and gates unit enables, with req/ack memory handshakes and an ack timeout.
module multicycle_sequencer #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    PC_STEP    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    TIMEOUT    = 15
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  run,
   output logic                  instrReq,
   output logic [ADDR_WIDTH-1:0] instrAddr,
   input  logic                  instrAck,
   input  logic [31:0]           instrData,
   output logic [31:0]           instruction,
   input  logic                  memReadFlag,
   input  logic                  memWriteFlag,
   input  logic                  regWriteFlag,
   input  logic                  branchFlag,
   input  logic                  ubranchFlag,
   input  logic                  zeroFlag,
   input  logic [ADDR_WIDTH-1:0] branchOffset,
   output logic                  aluEnable,
   output logic                  dataReq,
   output logic                  dataWrite,
   input  logic                  dataAck,
   output logic                  regWriteEn,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic [2:0]            state,
   output logic                  fault,
   output logic [31:0]           retired
);
   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3,
                          S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_FAULT = 3'd6;
   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [31:0]           instr_q, instr_d, retired_q, retired_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  take_q, take_d;
   logic                  waiting, ack, expired, commit;
   always_comb begin
      waiting = (state_q == S_FETCH) | (state_q == S_MEMORY);
      ack     = (state_q == S_FETCH) ? instrAck : dataAck;
      expired = waiting & ~ack & (cnt_q == 8'(TIMEOUT - 1));
      take_d  = (state_q == S_EXECUTE) ? (ubranchFlag | (branchFlag & zeroFlag)) : take_q;
      commit  = ((state_q == S_EXECUTE) & ~memReadFlag & ~memWriteFlag & ~regWriteFlag)
              | ((state_q == S_MEMORY) & dataAck & ~(memReadFlag & regWriteFlag))
              | (state_q == S_WRITEBACK);
      state_d = state_q;
      case (state_q)
         S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
         S_FETCH:     state_d = instrAck ? S_DECODE : S_FETCH;
         S_DECODE:    state_d = S_EXECUTE;
         S_EXECUTE:   state_d = (memReadFlag & memWriteFlag) ? S_FAULT :
                                (memReadFlag | memWriteFlag) ? S_MEMORY :
                                regWriteFlag ? S_WRITEBACK : S_FETCH;
         S_MEMORY:    state_d = ~dataAck ? S_MEMORY : (memReadFlag & regWriteFlag) ? S_WRITEBACK : S_FETCH;
         S_WRITEBACK: state_d = S_FETCH;
         default:     state_d = S_FAULT;
      endcase
      if (commit) state_d = run ? S_FETCH : S_IDLE;
      if (expired) state_d = S_FAULT;
      // the wait counter only survives while we stay in the same waiting state
      cnt_d     = (waiting & ~ack & (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;
      pc_d      = ~commit ? pc_q : take_d ? pc_q + (branchOffset << 2) : pc_q + ADDR_WIDTH'(PC_STEP);
      retired_d = retired_q + {31'b0, commit};
      instr_d   = ((state_q == S_FETCH) & instrAck) ? instrData : instr_q;
   end
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         cnt_q     <= '0;
         take_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
         cnt_q     <= cnt_d;
         take_q    <= take_d;
      end
   end
   assign instrReq    = state_q == S_FETCH;
   assign aluEnable   = state_q == S_EXECUTE;
   assign dataReq     = state_q == S_MEMORY;
   assign dataWrite   = dataReq & memWriteFlag;
   assign regWriteEn  = state_q == S_WRITEBACK;
   assign fault       = state_q == S_FAULT;
   assign instrAddr   = pc_q;
   assign pc          = pc_q;
   assign state       = state_q;
   assign instruction = instr_q;
   assign retired     = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed stimulus with hand-computed expectations for multicycle_sequencer.
module tb_multicycle_sequencer;
   logic        clock = 1'b0, resetN, run, instrAck, memReadFlag, memWriteFlag, regWriteFlag;
   logic        branchFlag, ubranchFlag, zeroFlag, dataAck;
   logic [31:0] instrData, branchOffset;
   logic        instrReq, aluEnable, dataReq, dataWrite, regWriteEn, fault;
   logic [31:0] instrAddr, instruction, pc, retired;
   logic [2:0]  state;
   int          checks = 0, errors = 0, n;

   multicycle_sequencer dut (
      .clock(clock), .resetN(resetN), .run(run), .instrReq(instrReq), .instrAddr(instrAddr),
      .instrAck(instrAck), .instrData(instrData), .instruction(instruction),
      .memReadFlag(memReadFlag), .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag),
      .branchFlag(branchFlag), .ubranchFlag(ubranchFlag), .zeroFlag(zeroFlag),
      .branchOffset(branchOffset), .aluEnable(aluEnable), .dataReq(dataReq), .dataWrite(dataWrite),
      .dataAck(dataAck), .regWriteEn(regWriteEn), .pc(pc), .state(state), .fault(fault),
      .retired(retired)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetN = 1'b0; run = 1'b0; instrAck = 1'b0; instrData = 32'hDEADBEEF;
      memReadFlag = 1'b0; memWriteFlag = 1'b0; regWriteFlag = 1'b0;
      branchFlag = 1'b0; ubranchFlag = 1'b0; zeroFlag = 1'b0; dataAck = 1'b0; branchOffset = '0;
      #3;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_instrReq", 32'(instrReq), 32'd0);
      chk("rst_instruction", instruction, 32'h0);
      // ALU op with register write-back
      run = 1'b1; instrAck = 1'b1; regWriteFlag = 1'b1;
      #9 resetN = 1'b1;
      cyc; chk("alu_fetch", 32'(state), 32'd1); chk("alu_instrReq", 32'(instrReq), 32'd1);
      cyc; chk("alu_decode", 32'(state), 32'd2); chk("alu_ir", instruction, 32'hDEADBEEF);
      cyc; chk("alu_exec", 32'(state), 32'd3); chk("alu_aluEnable", 32'(aluEnable), 32'd1);
      cyc; chk("alu_wb", 32'(state), 32'd5); chk("alu_regWriteEn", 32'(regWriteEn), 32'd1);
      cyc; chk("alu_refetch", 32'(state), 32'd1); chk("alu_pc", pc, 32'h4); chk("alu_retired", retired, 32'd1);
      // load with three wait cycles
      memReadFlag = 1'b1; instrData = 32'h12345678;
      cyc; cyc; cyc;
      chk("ld_mem", 32'(state), 32'd4); chk("ld_dataWrite", 32'(dataWrite), 32'd0);
      chk("ld_ir", instruction, 32'h12345678);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) dataAck = 1'b1;
         n += int'(dataReq);
         cyc;
      end
      dataAck = 1'b0;
      chk("ld_dataReq_cycles", 32'(n), 32'd4);
      chk("ld_wb", 32'(state), 32'd5); chk("ld_regWriteEn", 32'(regWriteEn), 32'd1);
      cyc; chk("ld_regWriteEn_off", 32'(regWriteEn), 32'd0); chk("ld_pc", pc, 32'h8);
      chk("ld_retired", retired, 32'd2);
      // two plain ops bring pc to 0x10
      memReadFlag = 1'b0; regWriteFlag = 1'b0;
      cyc; cyc; cyc; chk("nop1_pc", pc, 32'hC);
      cyc; cyc; cyc; chk("nop2_pc", pc, 32'h10); chk("nop_retired", retired, 32'd4);
      // branches
      branchFlag = 1'b1; zeroFlag = 1'b1; branchOffset = 32'hFFFFFFFE;
      cyc; cyc; cyc; chk("cbz_taken_pc", pc, 32'h8);
      branchFlag = 1'b0; ubranchFlag = 1'b1; zeroFlag = 1'b0; branchOffset = 32'd2;
      cyc; cyc; cyc; chk("ub_pc", pc, 32'h10);
      ubranchFlag = 1'b0; branchFlag = 1'b1; branchOffset = 32'hFFFFFFFE;
      cyc; cyc; cyc; chk("cbz_not_taken_pc", pc, 32'h14); chk("br_retired", retired, 32'd7);
      branchFlag = 1'b0;
      // store with run dropped during EXECUTE
      memWriteFlag = 1'b1; dataAck = 1'b1;
      cyc; cyc; chk("st_exec", 32'(state), 32'd3); run = 1'b0;
      cyc; chk("st_mem", 32'(state), 32'd4); chk("st_dataWrite", 32'(dataWrite), 32'd1);
      cyc; chk("st_idle", 32'(state), 32'd0); chk("st_retired", retired, 32'd8); chk("st_pc", pc, 32'h18);
      memWriteFlag = 1'b0; dataAck = 1'b0;
      cyc; chk("idle_parked", 32'(state), 32'd0);
      // fetch timeout
      instrAck = 1'b0; run = 1'b1;
      cyc; chk("to_fetch", 32'(state), 32'd1);
      repeat (14) cyc;
      chk("to_still_fetch", 32'(state), 32'd1);
      cyc; chk("to_fault_state", 32'(state), 32'd6); chk("to_fault", 32'(fault), 32'd1);
      chk("to_pc", pc, 32'h18); chk("to_retired", retired, 32'd8); chk("to_instrReq", 32'(instrReq), 32'd0);
      instrAck = 1'b1;
      repeat (3) cyc;
      chk("fault_sticky", 32'(state), 32'd6);
      // asynchronous reset clears fault
      #2 resetN = 1'b0;
      #1 chk("arst_state", 32'(state), 32'd0); chk("arst_fault", 32'(fault), 32'd0); chk("arst_pc", pc, 32'h0);
      memReadFlag = 1'b1; memWriteFlag = 1'b1;
      #3 resetN = 1'b1;
      // load and store together is illegal
      cyc; cyc; cyc; chk("ill_exec", 32'(state), 32'd3);
      cyc; chk("ill_fault", 32'(fault), 32'd1); chk("ill_retired", retired, 32'd0);
      chk("ill_aluEnable", 32'(aluEnable), 32'd0);
      // reset landing in MEMORY
      resetN = 1'b0; memReadFlag = 1'b0; memWriteFlag = 1'b0;
      #2 resetN = 1'b1;
      cyc; cyc; cyc; cyc; chk("mr_pc4", pc, 32'h4);
      memReadFlag = 1'b1;
      cyc; cyc; cyc; chk("mr_dataReq", 32'(dataReq), 32'd1);
      #2 resetN = 1'b0;
      #1 chk("mr_dataReq_off", 32'(dataReq), 32'd0); chk("mr_pc", pc, 32'h0); chk("mr_state", 32'(state), 32'd0);
      resetN = 1'b1; memReadFlag = 1'b0;
      // pc wrap through 0xFFFFFFFC
      ubranchFlag = 1'b1; branchOffset = 32'hFFFFFFFF;
      cyc; cyc; cyc; cyc; chk("wrap_pc_top", pc, 32'hFFFFFFFC);
      ubranchFlag = 1'b0;
      cyc; cyc; cyc; chk("wrap_pc_zero", pc, 32'h0);
      // ack arriving on the cycle the timeout would hit is accepted
      instrAck = 1'b0;
      repeat (14) cyc;
      chk("late_ack_fetch", 32'(state), 32'd1);
      instrAck = 1'b1;
      cyc; chk("late_ack_decode", 32'(state), 32'd2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
